// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: field widths, the Tuse
// "operand unused" encoding, HI/LO unit latencies and the Tnew class of each
// producer as it enters E.
package hazard_scoreboard_pkg;

  localparam int unsigned HS_TNEW_W   = 2;
  localparam int unsigned HS_MULT_LAT = 5;
  localparam int unsigned HS_DIV_LAT  = 10;
  localparam int unsigned HS_CNT_W    = 4;

  // Tuse value meaning "this operand is not read"
  localparam logic [HS_TNEW_W-1:0] TUSE_UNUSED = '1;

  // Tnew at E entry per producer class
  localparam logic [HS_TNEW_W-1:0] TNEW_PC8 = HS_TNEW_W'(0);
  localparam logic [HS_TNEW_W-1:0] TNEW_ALU = HS_TNEW_W'(1);
  localparam logic [HS_TNEW_W-1:0] TNEW_DM  = HS_TNEW_W'(2);

endpackage

// File: rtl/hs_match.sv
// Youngest-match priority encoder for one D-stage source operand.
// Ports:
//   valid_i  - D holds a real instruction
//   addr_i   - source register index
//   tuse_i   - cycles until the operand is needed (all-ones = unused)
//   a3_i     - destination index per tracked stage (1 = youngest)
//   tnew_i   - remaining Tnew per tracked stage
//   hazard_o - youngest producer is not ready in time (combinational)
//   sel_o    - stage to forward from in D, 0 = register file (combinational)
module hs_match #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TNEW_W = 2,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                           valid_i,
  input  logic [4:0]                     addr_i,
  input  logic [TNEW_W-1:0]              tuse_i,
  input  logic [STAGES:1][4:0]           a3_i,
  input  logic [STAGES:1][TNEW_W-1:0]    tnew_i,
  output logic                           hazard_o,
  output logic [SEL_W-1:0]               sel_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hazard_o = 1'b0;
    sel_o    = '0;
    if (valid_i && (addr_i != 5'd0) && (tuse_i != '1)) begin
      for (int k = int'(STAGES); k >= 1; k--) begin
        if (a3_i[k] == addr_i) begin
          hazard_o = (tnew_i[k] > tuse_i);
          sel_o    = (tnew_i[k] == '0) ? SEL_W'(k) : '0;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: shift-register scoreboard of (A3, Tnew) for the stages
// after D plus a HI/LO busy counter. Produces the D stall, the D forwarding
// selects for rs/rt and the HI/LO busy flag.
// Ports:
//   clk, reset            - clock, async active-low reset
//   d_*                   - decoded fields of the instruction in D
//   flush                 - send a bubble into stage 1 instead of D
//   stall                 - hold PC and F/D, bubble into E (combinational)
//   fwd_rs_sel/fwd_rt_sel - 0 = register file, k = stage k result
//   md_busy               - HI/LO unit busy
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned TNEW_W   = HS_TNEW_W,
  parameter int unsigned MULT_LAT = HS_MULT_LAT,
  parameter int unsigned DIV_LAT  = HS_DIV_LAT,
  parameter int unsigned CNT_W    = HS_CNT_W,
  localparam int unsigned SEL_W   = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [4:0]        d_a1,
  input  logic [4:0]        d_a2,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              md_busy
);

  logic [STAGES:1][4:0]        a3_q, a3_d;
  logic [STAGES:1][TNEW_W-1:0] tnew_q, tnew_d;
  logic [CNT_W-1:0]            md_cnt_q, md_cnt_d;

  logic hz_rs, hz_rt, md_stall, d_issue;

  hs_match #(.STAGES(STAGES), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_match_rs (
    .valid_i  (d_valid),
    .addr_i   (d_a1),
    .tuse_i   (d_tuse_rs),
    .a3_i     (a3_q),
    .tnew_i   (tnew_q),
    .hazard_o (hz_rs),
    .sel_o    (fwd_rs_sel)
  );

  hs_match #(.STAGES(STAGES), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_match_rt (
    .valid_i  (d_valid),
    .addr_i   (d_a2),
    .tuse_i   (d_tuse_rt),
    .a3_i     (a3_q),
    .tnew_i   (tnew_q),
    .hazard_o (hz_rt),
    .sel_o    (fwd_rt_sel)
  );

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = d_valid & d_md_use & md_busy;
  assign stall    = hz_rs | hz_rt | md_stall;
  // D instruction actually leaves D this cycle
  assign d_issue  = d_valid & ~stall & ~flush;

  // Scoreboard advance: Tnew counts down (floored at 0) as entries age.
  always_comb begin
    a3_d   = a3_q;
    tnew_d = tnew_q;
    for (int k = 2; k <= int'(STAGES); k++) begin
      a3_d[k]   = a3_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
    end
    a3_d[1]   = d_issue ? d_a3   : 5'd0;
    tnew_d[1] = d_issue ? d_tnew : '0;
  end

  // HI/LO busy counter: reload on an issuing md op, else count down to 0.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_issue && d_md_start) begin
      md_cnt_d = d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_q     <= '0;
      tnew_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      a3_q     <= a3_d;
      tnew_q   <= tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use, flush;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stall;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_a1       (d_a1),
    .d_a2       (d_a2),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input logic es, input logic [1:0] ers, input logic [1:0] ert,
                            input logic eb);
    exp_t e;
    e.stall = es;
    e.rs    = ers;
    e.rt    = ert;
    e.busy  = eb;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".stall"},   {7'd0, stall},      {7'd0, e.stall});
      chk({tag, ".rs_sel"},  {6'd0, fwd_rs_sel}, {6'd0, e.rs});
      chk({tag, ".rt_sel"},  {6'd0, fwd_rt_sel}, {6'd0, e.rt});
      chk({tag, ".md_busy"}, {7'd0, md_busy},    {7'd0, e.busy});
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic [1:0] tr,
                       input logic [4:0] a2, input logic [1:0] tt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu, input logic fl);
    d_valid    = v;
    d_a1       = a1;
    d_tuse_rs  = tr;
    d_a2       = a2;
    d_tuse_rt  = tt;
    d_a3       = a3;
    d_tnew     = tn;
    d_md_start = ms;
    d_md_div   = md;
    d_md_use   = mu;
    flush      = fl;
  endtask

  // One D-stage cycle: drive, record expectation, compare mid-cycle, clock.
  task automatic step(input logic v, input logic [4:0] a1, input logic [1:0] tr,
                      input logic [4:0] a2, input logic [1:0] tt,
                      input logic [4:0] a3, input logic [1:0] tn,
                      input logic ms, input logic md, input logic mu, input logic fl,
                      input logic es, input logic [1:0] ers, input logic [1:0] ert,
                      input logic eb, input string tag);
    drive(v, a1, tr, a2, tt, a3, tn, ms, md, mu, fl);
    expect_out(es, ers, ert, eb);
    #2;
    check_out(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic eb, input string tag);
    step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 2'd0, 2'd0, eb, tag);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_out(1'b0, 2'd0, 2'd0, 1'b0);
    check_out("reset_held");
    reset = 1'b1;
    idle(1'b0, "after_release");

    // lw $1 then add $2,$1,$3: one stall, then no stall with sel 0, then W fwd
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "lw1");
    step(1, 5'd1, 2'd1, 5'd3, 2'd1, 5'd2, 2'd1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, "add_stall");
    step(1, 5'd1, 2'd1, 5'd3, 2'd1, 5'd2, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "add_go");
    // reads $1 (at W, tnew 0) and $2 (add at stage 1, tnew 1, tuse 0)
    step(1, 5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 1, 2'd3, 2'd0, 0, "w_fwd_rt_hz");
    repeat (3) idle(1'b0, "drain1");

    // addu $1, bubble, beq $1: forward from stage 2
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "addu1");
    idle(1'b0, "bubble");
    step(1, 5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, "beq_fwd2");
    repeat (3) idle(1'b0, "drain2");

    // writes to $0 never create hazards or forwarding
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "w0_prod");
    step(1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "r0_cons");
    repeat (3) idle(1'b0, "drain3");

    // two writers to $5: youngest (lw) governs; rt unused ignores the ori
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "ori5");
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "lw5");
    step(1, 5'd5, 2'd0, 5'd5, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, "shadow_stall");
    step(1, 5'd5, 2'd0, 5'd5, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, "shadow_stall2");
    step(1, 5'd5, 2'd0, 5'd5, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, "shadow_fwd3");
    repeat (3) idle(1'b0, "drain4");

    // mult then mflo: exactly 5 stall cycles
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, "mult_issue");
    for (int i = 0; i < 5; i++)
      step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1, "mult_busy");
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, "mult_done");

    // div then mflo: exactly 10 stall cycles
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 0, "div_issue");
    for (int i = 0; i < 10; i++)
      step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1, "div_busy");
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, "div_done");

    // flush blocks the counter load and the stage-1 load
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1, 1, 1, 1, 0, 2'd0, 2'd0, 0, "div_flush");
    idle(1'b0, "div_flush_nocnt");
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd2, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, "lw6_flush");
    step(1, 5'd6, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, "after_flush");
    repeat (3) idle(1'b0, "drain5");

    // reset mid-operation with md_cnt=7 and lw $4 at stage 1
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 0, "div_pre_rst");
    idle(1'b1, "cnt10");
    idle(1'b1, "cnt9");
    step(1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, "lw4");
    drive(1, 5'd4, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 0);
    expect_out(1'b1, 2'd0, 2'd0, 1'b1);
    #2;
    check_out("pre_reset");
    reset = 1'b0;
    #1;
    expect_out(1'b0, 2'd0, 2'd0, 1'b0);
    check_out("reset_async");
    @(posedge clk);
    #1;
    expect_out(1'b0, 2'd0, 2'd0, 1'b0);
    check_out("reset_hold");
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_out(1'b0, 2'd0, 2'd0, 1'b0);
    check_out("first_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined MIPS core; successor to the one-hot Tuse/Tnew decoder scheme.
- Keeps a shift-register scoreboard of (A3, Tnew) for the STAGES in-flight stages after D, plus a multiply/divide busy counter.
- From these it produces the D-stage stall, the D-stage forwarding selects for rs/rt, and HI/LO busy.
- Sits beside the D/E pipeline register. It is fed by the instruction decoder; the datapath forwarding muxes consume its outputs.

Parameters:
STAGES, 3, number of tracked stages after D (1=E, 2=M, 3=W)
TNEW_W, 2, width of the Tuse/Tnew fields
MULT_LAT, 5, HI/LO busy cycles after mult/multu leaves D
DIV_LAT, 10, HI/LO busy cycles after div/divu leaves D
CNT_W, 4, busy-counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
d_valid  in  1  D holds a real instruction
d_a1  in  5  rs index
d_a2  in  5  rt index
d_tuse_rs  in  TNEW_W  cycles until rs is needed; all-ones = rs unused
d_tuse_rt  in  TNEW_W  same for rt
d_a3  in  5  destination register; 0 = no write
d_tnew  in  TNEW_W  cycles after entering E until the result is forwardable
d_md_start  in  1  mult/multu/div/divu in D
d_md_div  in  1  qualifies d_md_start: 1 = divide
d_md_use  in  1  D instruction touches HI/LO (md op, mfhi/mflo/mthi/mtlo)
flush  in  1  insert a bubble into stage 1 instead of the D instruction
stall  out  1  hold PC and F/D; bubble into E
fwd_rs_sel  out  SEL_W  0 = register file, k = result register of stage k
fwd_rt_sel  out  SEL_W  same for rt
md_busy  out  1  HI/LO unit busy
SEL_W = $clog2(STAGES+1), local.

Behaviour:
- State: a3[1..STAGES] (5 bits each), tnew[1..STAGES] (TNEW_W bits each), md_cnt (CNT_W bits).
- Reset (reset low, asynchronous): all a3, tnew and md_cnt clear to 0. Hence stall=0, fwd_*_sel=0, md_busy=0 while reset is held and on the first cycle after release.
- Advance every clock: entry k+1 takes a3[k] and sat_dec(tnew[k]), where sat_dec floors at 0. Entry STAGES is discarded.
- Stage 1 load: if d_valid & !stall & !flush, load a3=d_a3 and tnew=d_tnew. Otherwise load a bubble (a3=0, tnew=0).
- Match rule for rs: a match is any k with a3[k]==d_a1, d_a1!=0, d_valid, and d_tuse_rs != all-ones. Only the youngest match (lowest k) counts; older matches are shadowed.
- rs data hazard: youngest match has tnew[k] > d_tuse_rs.
- rs forward: youngest match has tnew[k]==0 gives fwd_rs_sel=k; otherwise fwd_rs_sel=0. If tnew is nonzero but within Tuse, downstream per-stage forwarding handles it and the D select stays 0.
- rt: identical rules using d_a2 and d_tuse_rt.
- md_busy = (md_cnt != 0).
- md stall: d_valid & d_md_use & md_busy.
- stall = rs hazard | rt hazard | md stall. It is purely combinational from state and D inputs, with no internal latency.
- md_cnt update:
  - loads DIV_LAT if d_md_div, else MULT_LAT, when d_md_start & d_valid & !stall & !flush;
  - otherwise decrements when nonzero;
  - holds at 0.
- flush: affects only the stage-1 load. In-flight entries and a running md_cnt are not cancelled. A flush with an md_start in D prevents the counter load.
- Simultaneous stall and flush: a bubble enters, same as stall alone.
- Reset mid-operation clears every hazard immediately, including a pending md count.

Decomposition:
- Shared package/header: TNEW_W, the Tuse "unused" encoding (all-ones), MULT_LAT/DIV_LAT defaults, and named Tnew constants (ALU=1, DM=2, PC8=0 at E entry). These sit alongside the existing op/func field macros.
- One natural sub-module: hs_match. It is instantiated twice (rs, rt) and is purely combinational, giving youngest-match priority encoding to hazard and select.
- Scoreboard shift and md counter live in the top module.

Test Plan:
- lw $1 (d_tnew=2) then add $2,$1,$3 (tuse_rs=1): stall=1 for one cycle. Next cycle stall=0 and fwd_rs_sel=0; one cycle later tnew[3]=0.
- addu $1 (tnew=1), one bubble, then beq $1 (tuse_rs=0): with addu at stage 2, tnew=0 and fwd_rs_sel=2, stall=0.
- Producer writes $0 (tnew=2), consumer reads $0 with tuse 0: stall=0, fwd sel=0.
- Two in-flight writers to $5, lw at stage 1 (tnew=2) and ori at stage 2 (tnew=0), with a consumer of tuse 0: youngest match governs, so stall=1.
- mult leaves D, then mflo in D: md_busy=1 and stall=1 for exactly MULT_LAT=5 cycles, then stall=0. Same with div gives 10 cycles.
- div in D with flush=1: md_cnt stays 0. Separately, assert reset low while md_cnt=7 and stage 1 holds lw $4: all outputs 0 immediately.
